// File: rtl/fetch_budget_ctrl.sv
// Run controller: grants each core a shared fetch budget, drops its fetch enable when spent,
// waits for retirement, and ends the run on completion, abort or retire-watchdog timeout.
module fetch_budget_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int TMO_W    = 20,
  parameter int WAIT_RET = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [CNT_W-1:0]          limit_i,
  input  logic [TMO_W-1:0]          timeout_i,
  input  logic [NUM_CH-1:0]         fetch_i,
  input  logic [NUM_CH-1:0]         retire_i,
  output logic [NUM_CH-1:0]         enable_o,
  output logic                      busy_o,
  output logic                      finished_o,
  output logic                      timeout_o,
  output logic [NUM_CH*CNT_W-1:0]   fetch_cnt_o,
  output logic [NUM_CH*CNT_W-1:0]   retire_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   wd_q, wd_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   fcnt_q [NUM_CH];
  logic [CNT_W-1:0]   fcnt_d [NUM_CH];
  logic [CNT_W-1:0]   rcnt_q [NUM_CH];
  logic [CNT_W-1:0]   rcnt_d [NUM_CH];

  logic               active;
  logic               start_ok;
  logic               all_ret;
  logic               drain_done;
  logic               wd_hit;
  logic [TMO_W:0]     wd_inc;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] sat_wd(input logic [TMO_W-1:0] v);
    return (v == '1) ? v : v + TMO_W'(1);
  endfunction

  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_ok = start_i && !active;
  assign wd_inc   = {1'b0, wd_q} + {{TMO_W{1'b0}}, 1'b1};
  // The watchdog fires on the idle cycle that brings the count up to tmo_q.
  assign wd_hit   = active && !(|retire_i) && (tmo_q != '0) && (wd_inc == {1'b0, tmo_q});

  always_comb begin
    all_ret = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rcnt_q[c] < limit_q) all_ret = 1'b0;
    end
  end

  assign drain_done = (state_q == S_DRAIN) && ((WAIT_RET == 0) || all_ret);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = (limit_i != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (abort_i || wd_hit) state_d = S_DONE;
        else if (en_q == '0)   state_d = S_DRAIN;
      end
      S_DRAIN: if (abort_i || drain_done || wd_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = active;
    finished_o = (state_q == S_DONE);
  end

  // Datapath: counters, enables and watchdog; abort freezes counters in its own cycle.
  always_comb begin
    limit_d = limit_q;
    tmo_d   = tmo_q;
    wd_d    = wd_q;
    en_d    = en_q;
    to_d    = to_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    if (start_ok) begin
      limit_d = limit_i;
      tmo_d   = timeout_i;
      wd_d    = '0;
      to_d    = 1'b0;
      en_d    = (limit_i != '0) ? '1 : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        fcnt_d[c] = '0;
        rcnt_d[c] = '0;
      end
    end else if (active && abort_i) begin
      en_d = '0;
      to_d = 1'b0;
    end else if (active) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_q[c] && fetch_i[c]) begin
          fcnt_d[c] = sat_cnt(fcnt_q[c]);
          if (sat_cnt(fcnt_q[c]) == limit_q) en_d[c] = 1'b0;
        end
        if (retire_i[c]) rcnt_d[c] = sat_cnt(rcnt_q[c]);
      end
      wd_d = (|retire_i) ? '0 : sat_wd(wd_q);
      if (!drain_done && wd_hit) begin
        to_d = 1'b1;
        en_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      limit_q <= '0;
      tmo_q   <= '0;
      wd_q    <= '0;
      en_q    <= '0;
      to_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        fcnt_q[c] <= '0;
        rcnt_q[c] <= '0;
      end
    end else begin
      limit_q <= limit_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      to_q    <= to_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign enable_o  = en_q;
  assign timeout_o = to_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign fetch_cnt_o[c*CNT_W +: CNT_W]  = fcnt_q[c];
    assign retire_cnt_o[c*CNT_W +: CNT_W] = rcnt_q[c];
  end

endmodule

// File: tb/tb_fetch_budget_ctrl.sv
// Bench for fetch_budget_ctrl: a wide WAIT_RET=1 instance and a narrow WAIT_RET=0 instance
// share stimulus and are compared each cycle against a per-instance behavioural model.
module tb_fetch_budget_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s_start, s_abort;
  logic [31:0] s_limit;
  logic [19:0] s_tmo;
  logic [1:0]  s_fetch, s_retire;

  logic [1:0]  en0, en1;
  logic        busy0, busy1, fin0, fin1, to0, to1;
  logic [63:0] fc0, rc0;
  logic [7:0]  fc1, rc1;

  int checks = 0;
  int errors = 0;

  // Model state per instance: st 0=idle 1=run 2=drain 3=done
  int          m_st  [2];
  longint      m_lim [2];
  longint      m_tmo [2];
  longint      m_wd  [2];
  longint      m_fc  [2][2];
  longint      m_rc  [2][2];
  logic [1:0]  m_en  [2];
  logic        m_to  [2];

  fetch_budget_ctrl #(.NUM_CH(2), .CNT_W(32), .TMO_W(20), .WAIT_RET(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .abort_i(s_abort),
    .limit_i(s_limit), .timeout_i(s_tmo), .fetch_i(s_fetch), .retire_i(s_retire),
    .enable_o(en0), .busy_o(busy0), .finished_o(fin0), .timeout_o(to0),
    .fetch_cnt_o(fc0), .retire_cnt_o(rc0));

  fetch_budget_ctrl #(.NUM_CH(2), .CNT_W(4), .TMO_W(6), .WAIT_RET(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .abort_i(s_abort),
    .limit_i(s_limit[3:0]), .timeout_i(s_tmo[5:0]), .fetch_i(s_fetch), .retire_i(s_retire),
    .enable_o(en1), .busy_o(busy1), .finished_o(fin1), .timeout_o(to1),
    .fetch_cnt_o(fc1), .retire_cnt_o(rc1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_lim[k] = 0; m_tmo[k] = 0; m_wd[k] = 0;
      m_en[k] = 2'b00; m_to[k] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_fc[k][c] = 0; m_rc[k][c] = 0;
      end
    end
  endtask

  task automatic model_step(input int k);
    longint cmax = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    longint tmax = (k == 0) ? 64'hF_FFFF : 64'd63;
    bit     wr   = (k == 0);
    bit     anyr, allr, dn, hit, enclr;
    if ((m_st[k] == 0 || m_st[k] == 3) && s_start) begin
      m_lim[k] = longint'(s_limit) & cmax;
      m_tmo[k] = longint'(s_tmo) & tmax;
      m_wd[k]  = 0;
      m_to[k]  = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_fc[k][c] = 0; m_rc[k][c] = 0;
      end
      m_st[k] = (m_lim[k] != 0) ? 1 : 3;
      m_en[k] = (m_lim[k] != 0) ? 2'b11 : 2'b00;
    end else if (m_st[k] == 1 || m_st[k] == 2) begin
      if (s_abort) begin
        m_st[k] = 3;
        m_en[k] = 2'b00;
      end else begin
        anyr = (s_retire != 2'b00);
        allr = 1'b1;
        for (int c = 0; c < 2; c++) if (m_rc[k][c] < m_lim[k]) allr = 1'b0;
        dn    = (m_st[k] == 2) && (!wr || allr);
        hit   = !anyr && (m_tmo[k] != 0) && (m_wd[k] + 1 == m_tmo[k]);
        enclr = (m_en[k] == 2'b00);
        for (int c = 0; c < 2; c++) begin
          if (m_en[k][c] && s_fetch[c]) begin
            if (m_fc[k][c] < cmax) m_fc[k][c]++;
            if (m_fc[k][c] == m_lim[k]) m_en[k][c] = 1'b0;
          end
          if (s_retire[c] && m_rc[k][c] < cmax) m_rc[k][c]++;
        end
        m_wd[k] = anyr ? 0 : ((m_wd[k] < tmax) ? m_wd[k] + 1 : tmax);
        if (dn) m_st[k] = 3;
        else if (hit) begin
          m_st[k] = 3; m_to[k] = 1'b1; m_en[k] = 2'b00;
        end else if (m_st[k] == 1 && enclr) m_st[k] = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("d0_en",   64'(en0),   64'(m_en[0]));
    chk("d0_busy", 64'(busy0), 64'(m_st[0] == 1 || m_st[0] == 2));
    chk("d0_fin",  64'(fin0),  64'(m_st[0] == 3));
    chk("d0_to",   64'(to0),   64'(m_to[0]));
    chk("d1_en",   64'(en1),   64'(m_en[1]));
    chk("d1_busy", 64'(busy1), 64'(m_st[1] == 1 || m_st[1] == 2));
    chk("d1_fin",  64'(fin1),  64'(m_st[1] == 3));
    chk("d1_to",   64'(to1),   64'(m_to[1]));
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("d0_fcnt%0d", c), 64'(fc0[c*32 +: 32]), 64'(m_fc[0][c]));
      chk($sformatf("d0_rcnt%0d", c), 64'(rc0[c*32 +: 32]), 64'(m_rc[0][c]));
      chk($sformatf("d1_fcnt%0d", c), 64'(fc1[c*4 +: 4]),   64'(m_fc[1][c]));
      chk($sformatf("d1_rcnt%0d", c), 64'(rc1[c*4 +: 4]),   64'(m_rc[1][c]));
    end
  endtask

  task automatic cyc(input logic st, input logic ab, input logic [31:0] lim,
                     input logic [19:0] tm, input logic [1:0] f, input logic [1:0] r);
    s_start = st; s_abort = ab; s_limit = lim; s_tmo = tm; s_fetch = f; s_retire = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
    s_start = 1'b0; s_abort = 1'b0; s_fetch = 2'b00; s_retire = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_limit = '0; s_tmo = '0;
    s_fetch = 2'b00; s_retire = 2'b00;
    model_reset();
    #12;
    check_all();
    chk("rst_en", 64'(en0), 64'd0);
    rst_n = 1'b1;

    // T1: limit 4, both channels fetch every cycle
    cyc(1, 0, 4, 0, 2'b00, 2'b00);
    chk("t1_en_on", 64'(en0), 64'd3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 2'b11, 2'b11);
    chk("t1_en_off", 64'(en0), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    chk("t1_fcnt", fc0, {32'd4, 32'd4});
    chk("t1_fin", 64'(fin0), 64'd1);
    chk("t1_to", 64'(to0), 64'd0);

    // T2: limit 3, ch0 back-to-back, ch1 once per 5 cycles
    cyc(1, 0, 3, 0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, {(i % 5 == 4), 1'b1}, 2'b00);
    chk("t2_fcnt", fc0, {32'd3, 32'd3});
    chk("t2_busy", 64'(busy0), 64'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 2'b00, 2'b11);
    chk("t2_fin", 64'(fin0), 64'd1);

    // T3: watchdog, then a retire on the 9th cycle restarts the window
    cyc(1, 0, 2, 10, 2'b00, 2'b00);
    for (int n = 1; n <= 9; n++) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    chk("t3_busy9", 64'(busy0), 64'd1);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    chk("t3_fin", 64'(fin0), 64'd1);
    chk("t3_to", 64'(to0), 64'd1);
    cyc(1, 0, 2, 10, 2'b00, 2'b00);
    for (int n = 1; n <= 18; n++) cyc(0, 0, 0, 0, 2'b11, (n == 9) ? 2'b01 : 2'b00);
    chk("t3_busy18", 64'(busy0), 64'd1);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    chk("t3_to2", 64'(to0), 64'd1);

    // T4: zero budget, then restart clears timeout and counters
    cyc(1, 0, 0, 0, 2'b11, 2'b00);
    chk("t4_fin", 64'(fin0), 64'd1);
    chk("t4_en", 64'(en0), 64'd0);
    chk("t4_to", 64'(to0), 64'd0);
    cyc(1, 0, 5, 0, 2'b00, 2'b00);
    chk("t4_busy", 64'(busy0), 64'd1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 2'b11, 2'b11);
    chk("t4_fcnt", fc0, {32'd5, 32'd5});

    // T5: abort mid-run, then abort/timeout coinciding with drain completion
    cyc(1, 0, 8, 0, 2'b00, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 1, 0, 0, 2'b11, 2'b00);
    chk("t5_fcnt", fc0, {32'd2, 32'd2});
    chk("t5_en", 64'(en0), 64'd0);
    cyc(0, 1, 0, 0, 2'b00, 2'b00);
    chk("t5_fin", 64'(fin0), 64'd1);
    cyc(1, 0, 1, 2, 2'b00, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b11);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    cyc(0, 1, 0, 0, 2'b00, 2'b00);
    chk("t5_abort_to", 64'(to0), 64'd0);
    cyc(1, 0, 1, 2, 2'b00, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b11);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);
    chk("t5_drain_to", 64'(to0), 64'd0);
    chk("t5_drain_fin", 64'(fin0), 64'd1);

    // T6: saturation in the narrow instance
    cyc(1, 0, 15, 0, 2'b00, 2'b00);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, {(i % 3 == 2), 1'b1}, 2'b11);
    chk("t6_sat_rc", 64'(rc1), 64'hFF);
    chk("t6_sat_fc", 64'(fc1), 64'hFF);
    chk("t6_wide_rc", rc0, {32'd47, 32'd47});

    // T6: asynchronous reset between clock edges
    cyc(1, 0, 10, 0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2'b11, 2'b01);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_en0", 64'(en0), 64'd0);
    chk("t6_rst_en1", 64'(en1), 64'd0);
    check_all();
    #2;
    rst_n = 1'b1;

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      logic        st, ab;
      logic [31:0] lim;
      logic [19:0] tm;
      st  = ($urandom_range(0, 11) == 0);
      ab  = ($urandom_range(0, 39) == 0);
      lim = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      tm  = ($urandom_range(0, 2) == 0) ? 20'd0 : 20'($urandom_range(1, 20));
      cyc(st, ab, lim, tm, 2'($urandom), ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
